pipelined_csel_addsub: RTL and testbench

//  Parametrised, two-stage pipelined signed carry-select adder/subtractor with

---
 rtl/csel_pkg.sv | 17 +
 rtl/csel_segment.sv | 16 +
 rtl/pipelined_csel_addsub.sv | 184 ++++++++++++++++++
 tb/tb_pipelined_csel_addsub.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared opcodes and saturation constants for the pipelined carry-select adder/subtractor.
package csel_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    // Most-negative (neg=1) or most-positive (neg=0) value of a width-bit signed number,
    // returned zero-extended to 64 bits; callers slice the low width bits.
    function automatic logic [63:0] sat_const(input int unsigned width, input logic neg);
        logic [63:0] msb;
        msb = 64'd1 << (width - 1);
        return neg ? msb : (msb - 64'd1);
    endfunction

endpackage

// File: rtl/csel_segment.sv
// One carry-select slice: sum and carry-out for both possible carry-ins.
module csel_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    output logic [SEG-1:0] s0,
    output logic [SEG-1:0] s1,
    output logic           c0,
    output logic           c1
);

    assign {c0, s0} = {1'b0, x} + {1'b0, y};
    assign {c1, s1} = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, 1'b1};

endmodule

// File: rtl/pipelined_csel_addsub.sv
// Two-stage signed carry-select add/sub with flags, optional saturation and a
// single global advance shared by both stages.
module pipelined_csel_addsub
    import csel_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SEG    = 4,
    parameter int SAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NSEG = WIDTH / SEG;

    if ((WIDTH % SEG) != 0 || WIDTH > 64) begin : g_bad_params
        $error("pipelined_csel_addsub: WIDTH must be a multiple of SEG and at most 64");
    end

    // Handshake: one advance for the whole pipe, adv = ~out_valid | out_ready.
    // When adv=0 every register holds; a beat enters on in_valid & in_ready and
    // leaves on out_valid & out_ready; empty slots advance like beats.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_p;
    logic             c_in0;

    always_comb begin
        b_p = op[0] ? ~b : b;
        case (op)
            OP_ADD:  c_in0 = 1'b0;
            OP_SUB:  c_in0 = 1'b1;
            default: c_in0 = cin;
        endcase
    end

    logic [SEG-1:0] seg_s0 [NSEG];
    logic [SEG-1:0] seg_s1 [NSEG];
    logic           seg_c0 [NSEG];
    logic           seg_c1 [NSEG];

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        csel_segment #(.SEG(SEG)) u_seg (
            .x  (a[g*SEG +: SEG]),
            .y  (b_p[g*SEG +: SEG]),
            .s0 (seg_s0[g]),
            .s1 (seg_s1[g]),
            .c0 (seg_c0[g]),
            .c1 (seg_c1[g])
        );
    end

    // Stage 1 state
    logic           v1_q, v1_d;
    logic           amsb_q, amsb_d, bmsb_q, bmsb_d, sat1_q, sat1_d;
    logic [SEG-1:0] s0_q [NSEG];
    logic [SEG-1:0] s0_d [NSEG];
    logic [SEG-1:0] s1_q [NSEG];
    logic [SEG-1:0] s1_d [NSEG];
    logic           c0_q [NSEG];
    logic           c0_d [NSEG];
    logic           c1_q [NSEG];
    logic           c1_d [NSEG];

    logic load1;
    assign load1 = adv & in_valid;

    always_comb begin
        v1_d   = adv ? in_valid : v1_q;
        amsb_d = load1 ? a[WIDTH-1]   : amsb_q;
        bmsb_d = load1 ? b_p[WIDTH-1] : bmsb_q;
        sat1_d = load1 ? sat          : sat1_q;
        for (int i = 0; i < NSEG; i++) begin
            s0_d[i] = s0_q[i];
            s1_d[i] = s1_q[i];
            c0_d[i] = c0_q[i];
            c1_d[i] = c1_q[i];
            if (load1) begin
                s0_d[i] = seg_s0[i];
                s1_d[i] = seg_s1[i];
                c0_d[i] = seg_c0[i];
                c1_d[i] = seg_c1[i];
            end
        end
        // Slice 0 already knows its carry-in, so both halves hold the resolved pair.
        if (load1) begin
            s0_d[0] = c_in0 ? seg_s1[0] : seg_s0[0];
            s1_d[0] = s0_d[0];
            c0_d[0] = c_in0 ? seg_c1[0] : seg_c0[0];
            c1_d[0] = c0_d[0];
        end
    end

    // Stage 2: ripple the selects and finish the flags
    logic [WIDTH-1:0] sum_w, res_w;
    logic [63:0]      sat_full;
    logic             sel_w, ovf_w;

    always_comb begin
        sel_w = 1'b0;
        sum_w = '0;
        for (int i = 0; i < NSEG; i++) begin
            sum_w[i*SEG +: SEG] = sel_w ? s1_q[i] : s0_q[i];
            sel_w               = sel_w ? c1_q[i] : c0_q[i];
        end
        ovf_w    = (amsb_q == bmsb_q) & (sum_w[WIDTH-1] != amsb_q);
        sat_full = sat_const(WIDTH, amsb_q);
        res_w    = ((SAT_EN != 0) && sat1_q && ovf_w) ? sat_full[WIDTH-1:0] : sum_w;
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, overflow_q, overflow_d;
    logic             zero_q, zero_d, negative_q, negative_d;
    logic             load2;
    assign load2 = adv & v1_q;

    always_comb begin
        out_valid_d = adv ? v1_q : out_valid_q;
        result_d    = load2 ? res_w            : result_q;
        carry_d     = load2 ? sel_w            : carry_q;
        overflow_d  = load2 ? ovf_w            : overflow_q;
        zero_d      = load2 ? (res_w == '0)    : zero_q;
        negative_d  = load2 ? res_w[WIDTH-1]   : negative_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            amsb_q      <= 1'b0;
            bmsb_q      <= 1'b0;
            sat1_q      <= 1'b0;
            s0_q        <= '{default: '0};
            s1_q        <= '{default: '0};
            c0_q        <= '{default: 1'b0};
            c1_q        <= '{default: 1'b0};
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            amsb_q      <= amsb_d;
            bmsb_q      <= bmsb_d;
            sat1_q      <= sat1_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Scoreboard bench for pipelined_csel_addsub at WIDTH=8, SEG=4, SAT_EN=1.
module tb_pipelined_csel_addsub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic [1:0] op = '0;
    logic       sat = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       carry, overflow, zero, negative;

    int total = 0;
    int bad = 0;
    int retired = 0;
    bit mon_en = 1'b0;

    // expected beat: {result, carry, overflow, zero, negative}
    logic [11:0] exp_q[$];

    pipelined_csel_addsub #(.WIDTH(8), .SEG(4), .SAT_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap or clamp to 8-bit signed range.
    function automatic logic [11:0] model(input logic [7:0] ta, input logic [7:0] tb,
                                          input logic [1:0] top, input logic tcin,
                                          input logic tsat);
        int sa, sb, cbit, tru, full;
        logic [7:0] res;
        logic cy, ov;
        sa   = $signed(ta);
        sb   = $signed(tb);
        cbit = (top == 2'b00) ? 0 : (top == 2'b01) ? 1 : int'(tcin);
        if (top[0]) begin
            tru  = sa - sb - 1 + cbit;
            full = int'(ta) + (255 - int'(tb)) + cbit;
        end else begin
            tru  = sa + sb + cbit;
            full = int'(ta) + int'(tb) + cbit;
        end
        cy  = (full > 255);
        ov  = (tru > 127) || (tru < -128);
        res = tru[7:0];
        if (tsat && ov) res = (tru > 127) ? 8'h7F : 8'h80;
        return {res, cy, ov, (res == 8'h00), res[7]};
    endfunction

    // One cycle of stimulus: set inputs just after the falling edge, report acceptance.
    task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [1:0] top, input logic tcin, input logic tsat,
                         input logic ordy, output logic acc);
        @(negedge clk);
        out_ready = ordy;
        in_valid  = v;
        a = ta; b = tb; op = top; cin = tcin; sat = tsat;
        #1;
        acc = v && in_ready;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                        input logic tcin, input logic tsat, input logic [11:0] expv);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) drive(1'b1, ta, tb, top, tcin, tsat, 1'b1, acc);
        check("send_accept", acc, 1'b1);
        if (acc) exp_q.push_back(expv);
    endtask

    // Monitor: a retire happens at the next rising edge when out_valid & out_ready.
    always begin
        @(negedge clk);
        #3;
        if (mon_en && rst_n && out_valid && out_ready) begin
            retired++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {20'h0, result, carry, overflow, zero, negative}, 32'hFFFFFFFF);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("beat", {20'h0, result, carry, overflow, zero, negative}, {20'h0, e});
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int k, r0, saw;

        // clock/reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_flags", {carry, overflow, zero, negative}, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Latency: presented in cycle n, visible in cycle n+2.
        drive(1'b1, 8'hFF, 8'h00, 2'b11, 1'b1, 1'b0, 1'b1, acc);
        check("lat_accept", acc, 1'b1);
        exp_q.push_back({8'hFF, 1'b1, 1'b0, 1'b0, 1'b1});
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, acc);
        check("lat_cycle1", out_valid, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, acc);
        check("lat_cycle2", out_valid, 1'b1);
        idle(2);

        // Directed vectors
        send(8'hFF, 8'hFF, 2'b01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        send(8'h80, 8'h80, 2'b00, 1'b0, 1'b0, {8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
        send(8'h80, 8'h80, 2'b00, 1'b0, 1'b1, {8'h80, 1'b1, 1'b1, 1'b0, 1'b1});
        send(8'h7F, 8'h01, 2'b00, 1'b0, 1'b1, {8'h7F, 1'b0, 1'b1, 1'b0, 1'b0});
        send(8'hFE, 8'hFE, 2'b00, 1'b0, 1'b0, {8'hFC, 1'b1, 1'b0, 1'b0, 1'b1});
        send(8'h7F, 8'h80, 2'b01, 1'b0, 1'b1, {8'h7F, 1'b0, 1'b1, 1'b0, 1'b0});
        send(8'h80, 8'h01, 2'b11, 1'b1, 1'b1, {8'h80, 1'b1, 1'b1, 1'b0, 1'b1});
        send(8'h7F, 8'h00, 2'b10, 1'b1, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0, 1'b1});
        drain();

        // Backpressure: 4 beats, out_ready low in cycles 3..5
        k = 0;
        r0 = retired;
        for (int c = 1; c <= 14; c++) begin
            logic ordy;
            logic [7:0] v;
            ordy = !(c >= 3 && c <= 5);
            v = 8'(k + 1);
            drive(k < 4, v, v, 2'b00, 1'b0, 1'b0, ordy, acc);
            if (acc) begin
                exp_q.push_back(model(v, v, 2'b00, 1'b0, 1'b0));
                k++;
            end
            if (c >= 3 && c <= 5) begin
                check("bp_out_valid", out_valid, 1'b1);
                check("bp_in_ready", in_ready, 1'b0);
                check("bp_hold", result, 8'h02);
            end
        end
        drain();
        check("bp_all_sent", k, 4);
        check("bp_retired", retired - r0, 4);

        // Reset with two beats in flight
        drive(1'b1, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 1'b1, acc);
        drive(1'b1, 8'h33, 8'h44, 2'b00, 1'b0, 1'b0, 1'b1, acc);
        @(negedge clk);
        in_valid = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_result", result, 8'h00);
        check("mid_rst_flags", {carry, overflow, zero, negative}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) saw++;
        end
        check("post_rst_no_beat", saw, 0);
        mon_en = 1'b1;

        // Random stream with random stalls
        for (int i = 0; i < 10000; i++) begin
            logic [7:0] ra, rb;
            logic [1:0] rop;
            logic rc, rs, rv, ro;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 2'($urandom_range(0, 3));
            rc  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 4) != 0);
            ro  = ($urandom_range(0, 3) != 0);
            drive(rv, ra, rb, rop, rc, rs, ro, acc);
            if (acc) exp_q.push_back(model(ra, rb, rop, rc, rs));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
